lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Synchronous controller for the push-button combination lock. It owns the lock's state, the stored combination, the failed-attempt count and all timing in the `hz100` domain. It consumes decoded key events (`key_valid` pulse plus 5-bit `key_code`, as produced by the key encoder/synchronizer). It drives registered status outputs that the seven-segment/RGB display logic renders.

## Interface
Parameters:
- `COMBO_LEN`, 8: combination length in bits (2..16).
- `MAX_TRIES`, 3: failed attempts that trigger ALARM (1..7).
- `ENTRY_TIMEOUT`, 500: idle cycles allowed between digits in ENTRY (5 s at 100 Hz).
- `LOCKOUT_TICKS`, 1000: cycles spent in LOCKOUT.
- `OPEN_TICKS`, 1000: idle cycles in OPEN before auto-relock.

Ports:
- `hz100` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `key_valid` in 1: one-cycle pulse marking a key event.
- `key_code` in 5: key index. 0 and 1 are data digits, 16 = ARM, 17 = PROG. All other codes are ignored.
- `state` out 3: current `lock_state_t` encoding.
- `bit_idx` out $clog2(COMBO_LEN): digits accepted so far in PROG or ENTRY.
- `tries` out 3: failed attempts since the last successful open.
- `combo` out COMBO_LEN: the stored combination, MSB entered first.
- `open` out 1: high in OPEN.
- `alarm` out 1: high in ALARM.

## Operation
- The FSM is Moore. All outputs are registered.
- Reset values: `state`=INIT, `combo`=0, `bit_idx`=0, `tries`=0, `open`=0, `alarm`=0, internal timer=0, error flag=0.
- A key counts only when `key_valid`=1 at the sampling edge. Each high cycle is one event.
- **INIT**
  - PROG goes to PROG with `combo` and `bit_idx` cleared.
  - All other keys are ignored.
- **PROG**
  - A digit shifts in: `combo` <= {combo[L-2:0], d}, and `bit_idx`++.
  - The digit that brings the count to L goes to ARMED with `bit_idx`=0.
  - ARM aborts to INIT and clears `combo`.
  - PROG is ignored. There is no timeout.
- **ARMED**
  - A digit goes to ENTRY and is treated as digit 0.
  - ARM and PROG are ignored.
- **ENTRY**
  - Digit i is compared with combo[L-1-i]. Any mismatch sets a sticky error flag. No early abort, so the wrong position is not revealed.
  - On digit L-1: if there is no error, go to OPEN with `tries`=0; otherwise take the fail path.
  - ARM cancels to ARMED. `tries` is unchanged and the error flag is cleared.
  - ENTRY_TIMEOUT cycles with no accepted key takes the fail path.
- **Fail path**
  - `tries`++.
  - If the new value equals MAX_TRIES, go to ALARM; otherwise go to LOCKOUT.
- **LOCKOUT**
  - All keys are ignored.
  - After LOCKOUT_TICKS cycles, go to ARMED.
- **OPEN**
  - ARM goes to ARMED.
  - PROG goes to PROG. Reprogramming is allowed only here.
  - Digits are ignored but do restart the idle timer.
  - OPEN_TICKS idle cycles go to ARMED.
- **ALARM**
  - Terminal state. Only `reset` exits.
- **Timer**
  - 16-bit up-counter.
  - Cleared on every state change and on every accepted key in ENTRY or OPEN.
  - Limit L is reached when the count equals L-1 and no key is present. The transition takes effect at that edge, so exactly L cycles are spent.
- **Width rules**
  - `tries` saturates at MAX_TRIES.
  - `bit_idx` never exceeds L-1.

## Timing
- Latency: `key_valid` at edge n is reflected on all outputs immediately after edge n (one cycle).
- A key in the same cycle as timer expiry takes precedence:
  - In ENTRY the digit is accepted and the timer is cleared. If it is digit L-1, the completion result applies.
  - In OPEN the key action or timer restart applies.
- `reset` is asserted asynchronously, mid-operation included: all registers go to reset values immediately. Deassertion takes effect at the next `hz100` edge.
- No combinational path exists from inputs to outputs.

## Structure
- Package `lock_pkg` holds:
  - `lock_state_t`: INIT=0, PROG=1, ARMED=2, ENTRY=3, OPEN=4, LOCKOUT=5, ALARM=6.
  - Constants `KEY_ARM`=16 and `KEY_PROG`=17.
- One sub-module, `tick_timer`: the clearable 16-bit counter with a `limit` input and an `expire` output.
- The FSM, combination register, error flag and attempt counter all live in `lock_sequencer`.

## Test plan
- **Program:** reset, PROG, then digits 1,0,1,1,0,0,1,0. Expect `combo`=8'hB2, state ARMED, `bit_idx`=0.
- **Open and relock:** enter 10110010. Expect OPEN, `open`=1, `tries`=0. With OPEN_TICKS=20 and no keys, expect ARMED exactly 20 cycles after entering OPEN.
- **Wrong entry:** enter 10110011. Expect LOCKOUT, `tries`=1. Digits during LOCKOUT are ignored. With LOCKOUT_TICKS=15, expect ARMED after exactly 15 cycles.
- **Alarm:** three wrong entries. Expect ALARM, `alarm`=1. ARM is ignored. Assert `reset` low mid-ALARM; expect INIT with `combo`=0 and `tries`=0 before the next clock edge.
- **Timeout:** with ENTRY_TIMEOUT=10, enter 3 digits then idle. Expect LOCKOUT with `tries`=1. Repeat with a digit landing on the expiry cycle; expect it accepted, `bit_idx`=4, state ENTRY.
- **Cancel and reprogram:** ARM mid-ENTRY returns to ARMED with `tries` unchanged. Open, then PROG with 8 new digits; expect the new `combo` and state ARMED.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and key codes for the combination lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_PROG    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_ENTRY   = 3'd3,
    ST_OPEN    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_ALARM   = 3'd6
  } lock_state_t;

  localparam logic [4:0] KEY_ARM  = 5'd16;
  localparam logic [4:0] KEY_PROG = 5'd17;

endpackage

// File: rtl/tick_timer.sv
// Clearable 16-bit up-counter; expire flags the last cycle of a limit-long interval.
module tick_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic        expire
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: restart on clear, otherwise count up.
  always_comb begin
    cnt_d = clear ? 16'd0 : cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  // The count sits at limit-1 during the limit-th cycle since the last clear.
  assign expire = (cnt_q == (limit - 16'd1));

endmodule

// File: rtl/lock_sequencer.sv
// Combination lock controller: FSM, stored combination, error flag, attempt counter.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int COMBO_LEN     = 8,
  parameter int MAX_TRIES     = 3,
  parameter int ENTRY_TIMEOUT = 500,
  parameter int LOCKOUT_TICKS = 1000,
  parameter int OPEN_TICKS    = 1000
) (
  input  logic                         hz100,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [4:0]                   key_code,
  output logic [2:0]                   state,
  output logic [$clog2(COMBO_LEN)-1:0] bit_idx,
  output logic [2:0]                   tries,
  output logic [COMBO_LEN-1:0]         combo,
  output logic                         open,
  output logic                         alarm
);

  localparam int IW = $clog2(COMBO_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(COMBO_LEN - 1);
  localparam logic [2:0]    TRY_MAX  = 3'(MAX_TRIES);

  lock_state_t          state_q, state_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [2:0]           tries_q, tries_d;
  logic [COMBO_LEN-1:0] combo_q, combo_d;
  logic                 err_q, err_d;
  logic                 open_q, open_d;
  logic                 alarm_q, alarm_d;

  logic                 is_digit, is_arm, is_prog, digit;
  logic                 key_acc, fail, mis, expire, tmr_clr;
  logic [2:0]           tries_inc;
  logic [15:0]          limit;
  logic [COMBO_LEN-1:0] combo_sh;

  assign is_digit = key_valid && (key_code[4:1] == 4'd0);
  assign is_arm   = key_valid && (key_code == KEY_ARM);
  assign is_prog  = key_valid && (key_code == KEY_PROG);
  assign digit    = key_code[0];

  // Expected digit for the current entry position: combo[L-1-bit_idx].
  assign combo_sh = combo_q << bit_idx_q;
  assign mis      = (digit != combo_sh[COMBO_LEN-1]);

  // Pick the interval that matters for the current state.
  always_comb begin
    case (state_q)
      ST_ENTRY:   limit = 16'(ENTRY_TIMEOUT);
      ST_OPEN:    limit = 16'(OPEN_TICKS);
      ST_LOCKOUT: limit = 16'(LOCKOUT_TICKS);
      default:    limit = 16'd0;
    endcase
  end

  // Next-state and datapath logic; keys take precedence over timer expiry.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    tries_d   = tries_q;
    combo_d   = combo_q;
    err_d     = err_q;
    key_acc   = 1'b0;
    fail      = 1'b0;
    tries_inc = (tries_q >= TRY_MAX) ? tries_q : tries_q + 3'd1;

    case (state_q)
      ST_INIT: begin
        if (is_prog) begin
          state_d   = ST_PROG;
          combo_d   = '0;
          bit_idx_d = '0;
        end
      end
      ST_PROG: begin
        if (is_digit) begin
          combo_d = {combo_q[COMBO_LEN-2:0], digit};
          if (bit_idx_q == LAST_IDX) begin
            state_d   = ST_ARMED;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else if (is_arm) begin
          state_d   = ST_INIT;
          combo_d   = '0;
          bit_idx_d = '0;
        end
      end
      ST_ARMED: begin
        if (is_digit) begin
          state_d   = ST_ENTRY;
          err_d     = (digit != combo_q[COMBO_LEN-1]);
          bit_idx_d = IW'(1);
        end
      end
      ST_ENTRY: begin
        if (is_digit) begin
          key_acc = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            err_d     = 1'b0;
            if (!(err_q || mis)) begin
              state_d = ST_OPEN;
              tries_d = 3'd0;
            end else begin
              fail = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            err_d     = err_q || mis;
          end
        end else if (is_arm) begin
          key_acc   = 1'b1;
          state_d   = ST_ARMED;
          bit_idx_d = '0;
          err_d     = 1'b0;
        end else if (expire) begin
          fail      = 1'b1;
          bit_idx_d = '0;
          err_d     = 1'b0;
        end
      end
      ST_LOCKOUT: begin
        if (expire) state_d = ST_ARMED;
      end
      ST_OPEN: begin
        if (is_arm) begin
          state_d = ST_ARMED;
        end else if (is_prog) begin
          state_d   = ST_PROG;
          combo_d   = '0;
          bit_idx_d = '0;
        end else if (is_digit) begin
          key_acc = 1'b1;
        end else if (expire) begin
          state_d = ST_ARMED;
        end
      end
      default: ;
    endcase

    if (fail) begin
      tries_d = tries_inc;
      state_d = (tries_inc == TRY_MAX) ? ST_ALARM : ST_LOCKOUT;
    end
  end

  assign open_d  = (state_d == ST_OPEN);
  assign alarm_d = (state_d == ST_ALARM);
  assign tmr_clr = (state_d != state_q) || key_acc;

  // State and output registers.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      bit_idx_q <= '0;
      tries_q   <= 3'd0;
      combo_q   <= '0;
      err_q     <= 1'b0;
      open_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      tries_q   <= tries_d;
      combo_q   <= combo_d;
      err_q     <= err_d;
      open_q    <= open_d;
      alarm_q   <= alarm_d;
    end
  end

  tick_timer u_timer (
    .clk    (hz100),
    .rst_n  (reset),
    .clear  (tmr_clr),
    .limit  (limit),
    .expire (expire)
  );

  assign state   = state_q;
  assign bit_idx = bit_idx_q;
  assign tries   = tries_q;
  assign combo   = combo_q;
  assign open    = open_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with short timer limits.
module tb_lock_sequencer;

  logic       hz100;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_code;
  logic [2:0] state;
  logic [2:0] bit_idx;
  logic [2:0] tries;
  logic [7:0] combo;
  logic       open;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] S_INIT = 3'd0, S_PROG = 3'd1, S_ARMED = 3'd2, S_ENTRY = 3'd3,
                         S_OPEN = 3'd4, S_LOCK = 3'd5, S_ALARM = 3'd6;
  localparam logic [4:0] K_ARM = 5'd16, K_PROG = 5'd17;

  lock_sequencer #(
    .COMBO_LEN(8), .MAX_TRIES(3), .ENTRY_TIMEOUT(10),
    .LOCKOUT_TICKS(15), .OPEN_TICKS(20)
  ) dut (
    .hz100(hz100), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .state(state), .bit_idx(bit_idx), .tries(tries), .combo(combo),
    .open(open), .alarm(alarm)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the key is sampled at the following posedge.
  task automatic press(input logic [4:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge hz100);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic enter8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) press({4'd0, v[i]});
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 5'd0;
    idle(2);
    chk("rst_state", state, S_INIT);
    chk("rst_combo", combo, 8'h00);
    chk("rst_bitidx", bit_idx, 3'd0);
    chk("rst_tries", tries, 3'd0);
    chk("rst_open", open, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    reset = 1'b1;
    idle(1);

    // Keys other than PROG are ignored in INIT
    press(K_ARM); press(5'd1);
    chk("init_ignore", state, S_INIT);

    // Program 10110010
    press(K_PROG);
    chk("prog_enter", state, S_PROG);
    press(5'd1); press(5'd0); press(5'd1);
    chk("prog_bitidx3", bit_idx, 3'd3);
    press(5'd1); press(5'd0); press(5'd0); press(5'd1); press(5'd0);
    chk("prog_combo", combo, 8'hB2);
    chk("prog_armed", state, S_ARMED);
    chk("prog_bitidx0", bit_idx, 3'd0);

    // Open and auto-relock after 20 cycles
    enter8(8'hB2);
    chk("open_state", state, S_OPEN);
    chk("open_flag", open, 1'b1);
    chk("open_tries", tries, 3'd0);
    idle(19);
    chk("open_hold19", state, S_OPEN);
    idle(1);
    chk("open_relock20", state, S_ARMED);
    chk("open_flag_low", open, 1'b0);

    // Wrong entry, lockout for 15 cycles with ignored digits
    enter8(8'hB3);
    chk("wrong_lock", state, S_LOCK);
    chk("wrong_tries1", tries, 3'd1);
    press(5'd1); press(5'd0);
    chk("lock_ign_bitidx", bit_idx, 3'd0);
    idle(12);
    chk("lock_hold14", state, S_LOCK);
    idle(1);
    chk("lock_exit15", state, S_ARMED);

    // Two more failures reach ALARM
    enter8(8'hB3);
    chk("wrong_tries2", tries, 3'd2);
    idle(15);
    chk("lock2_exit", state, S_ARMED);
    enter8(8'hB3);
    chk("alarm_state", state, S_ALARM);
    chk("alarm_flag", alarm, 1'b1);
    chk("alarm_tries", tries, 3'd3);
    press(K_ARM);
    chk("alarm_arm_ign", state, S_ALARM);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, S_INIT);
    chk("arst_combo", combo, 8'h00);
    chk("arst_tries", tries, 3'd0);
    chk("arst_alarm", alarm, 1'b0);
    @(negedge hz100);
    reset = 1'b1;
    idle(1);

    // Entry timeout after 10 idle cycles
    press(K_PROG);
    enter8(8'hB2);
    press(5'd1); press(5'd0); press(5'd1);
    chk("to_bitidx3", bit_idx, 3'd3);
    idle(9);
    chk("to_hold9", state, S_ENTRY);
    idle(1);
    chk("to_lock", state, S_LOCK);
    chk("to_tries", tries, 3'd1);
    chk("to_bitidx0", bit_idx, 3'd0);
    idle(15);
    chk("to_lock_exit", state, S_ARMED);

    // Digit landing on the expiry cycle is accepted
    press(5'd1); press(5'd0); press(5'd1);
    idle(9);
    press(5'd1);
    chk("race_state", state, S_ENTRY);
    chk("race_bitidx", bit_idx, 3'd4);
    idle(9);
    chk("race_restart", state, S_ENTRY);

    // ARM cancels entry, tries kept, error flag cleared
    press(K_ARM);
    chk("cancel_state", state, S_ARMED);
    chk("cancel_tries", tries, 3'd1);
    chk("cancel_bitidx", bit_idx, 3'd0);
    press(5'd0);
    press(K_ARM);
    enter8(8'hB2);
    chk("cancel_open", state, S_OPEN);
    chk("cancel_tries0", tries, 3'd0);

    // Digits in OPEN restart the idle timer
    idle(15); press(5'd0); idle(15);
    chk("open_restart", state, S_OPEN);

    // Reprogram from OPEN
    press(K_PROG);
    chk("reprog_state", state, S_PROG);
    enter8(8'h69);
    chk("reprog_combo", combo, 8'h69);
    chk("reprog_armed", state, S_ARMED);
    enter8(8'h69);
    chk("reprog_open", state, S_OPEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
